// File: rtl/rgb2luma.sv
// RGB to luma converter: Y = (77R + 150G + 29B + 128) >> 8.
// Two-stage pipeline (products, then rounded sum) with valid/ready flow control on both ports.
module rgb2luma #(
    parameter int ChannelWidth = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [3*ChannelWidth-1:0] data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [ChannelWidth-1:0]   data_o,
    input  logic                      ready_i
);

    // Each coefficient is below 256, so a product needs ChannelWidth+8 bits.
    localparam int ProdWidth = ChannelWidth + 8;
    localparam int SumWidth  = ChannelWidth + 10;
    localparam logic [SumWidth-1:0] RoundConst = SumWidth'(128);

    logic [2:0][ProdWidth-1:0] prod_next;
    logic [2:0][ProdWidth-1:0] prod_reg;
    logic                      v1_reg;
    logic                      v2_reg;
    logic [SumWidth-1:0]       sum_next;
    logic [ChannelWidth-1:0]   luma_next;
    logic [ChannelWidth-1:0]   luma_reg;
    logic                      s1_en;
    logic                      s2_en;
    logic                      unused_sum_bits;

    // Channel 0 is B (LSBs), channel 2 is R (MSBs).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            localparam logic [7:0] Coef = (gi == 2) ? 8'd77 : ((gi == 1) ? 8'd150 : 8'd29);
            logic [ProdWidth-1:0] chan_ext;
            assign chan_ext      = {8'd0, data_i[gi*ChannelWidth +: ChannelWidth]};
            assign prod_next[gi] = chan_ext * ProdWidth'(Coef);
        end
    endgenerate

    assign sum_next = SumWidth'(prod_reg[0]) + SumWidth'(prod_reg[1])
                    + SumWidth'(prod_reg[2]) + RoundConst;
    // Coefficients total 256, so the shifted sum always fits in ChannelWidth bits.
    assign luma_next       = sum_next[ChannelWidth+7:8];
    assign unused_sum_bits = ^{sum_next[7:0], sum_next[SumWidth-1:ChannelWidth+8]};

    // A stage may load when it is empty or when the stage after it is moving.
    assign s2_en = !v2_reg || ready_i;
    assign s1_en = !v1_reg || s2_en;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
            prod_reg <= '0;
            luma_reg <= '0;
        end else begin
            if (s1_en) begin
                v1_reg   <= valid_i;
                prod_reg <= prod_next;
            end
            if (s2_en) begin
                v2_reg   <= v1_reg;
                luma_reg <= luma_next;
            end
        end
    end

    // Handshakes are masked while reset is held so no transfer is ever reported then.
    assign ready_o = s1_en && !reset_i;
    assign valid_o = v2_reg && !reset_i;
    assign data_o  = luma_reg;

endmodule

// File: tb/tb_rgb2luma.sv
// Self-checking bench for rgb2luma: directed vectors, backpressure, full-rate streaming,
// random handshakes against an arithmetic reference model, and mid-stream reset.
module tb_rgb2luma;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [3*CW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic          valid_o;
    logic [CW-1:0] data_o;
    logic          ready_i;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int obs_q[$];
    int stab_err = 0;
    logic prev_stall = 1'b0;
    logic [CW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    rgb2luma #(.ChannelWidth(CW)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    function automatic int ref_luma(input logic [3*CW-1:0] px);
        int r, g, b;
        r = int'(px[3*CW-1 -: CW]);
        g = int'(px[2*CW-1 -: CW]);
        b = int'(px[CW-1:0]);
        return (77 * r + 150 * g + 29 * b + 128) / 256;
    endfunction

    function automatic logic [3*CW-1:0] rgb(input int r, input int g, input int b);
        return {CW'(r), CW'(g), CW'(b)};
    endfunction

    // Advance one cycle: record handshakes seen this cycle, then step past the clock edge.
    task automatic tick();
        #2;
        if (!reset_i) begin
            if (prev_stall && (valid_o !== 1'b1 || data_o !== prev_data)) stab_err++;
            if (valid_i && ready_o) exp_q.push_back(ref_luma(data_i));
            if (valid_o && ready_i) obs_q.push_back(int'(data_o));
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_scoreboard();
        exp_q.delete();
        obs_q.delete();
        stab_err = 0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o);
        else n_pass++;
        n_checks++;
        if (data_o !== '0) $display("FAIL reset_data: got %0d want 0", data_o);
        else n_pass++;
        n_checks++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o);
        else n_pass++;
        clear_scoreboard();
        $display("test_reset: valid_o=%b data_o=%0d ready_o=%b", valid_o, data_o, ready_o);
    endtask

    task automatic test_vectors();
        logic [3*CW-1:0] px [6];
        int              want [6];
        px[0] = rgb(255, 255, 255); want[0] = 255;
        px[1] = rgb(255, 0, 0);     want[1] = 77;
        px[2] = rgb(0, 255, 0);     want[2] = 149;
        px[3] = rgb(0, 0, 255);     want[3] = 29;
        px[4] = rgb(0, 0, 0);       want[4] = 0;
        px[5] = rgb(100, 100, 100); want[5] = 100;
        for (int i = 0; i < 6; i++) begin
            ready_i = 1'b1;
            valid_i = 1'b1;
            data_i  = px[i];
            #1;
            n_checks++;
            if (ready_o !== 1'b1) $display("FAIL vec%0d_accept: ready_o=%b want 1", i, ready_o);
            else n_pass++;
            tick();
            valid_i = 1'b0;
            n_checks++;
            if (valid_o !== 1'b0) $display("FAIL vec%0d_early: valid_o=%b want 0 at N+1", i, valid_o);
            else n_pass++;
            tick();
            n_checks++;
            if (valid_o !== 1'b1 || data_o !== CW'(want[i]))
                $display("FAIL vec%0d_luma: valid_o=%b data_o=%0d want 1/%0d", i, valid_o, data_o, want[i]);
            else n_pass++;
            $display("test_vectors: px=%06h luma=%0d expected=%0d", px[i], data_o, want[i]);
            tick();
        end
        clear_scoreboard();
    endtask

    task automatic test_backpressure();
        logic [3*CW-1:0] px [5];
        logic [CW-1:0]   held;
        int              acc;
        int              guard;
        logic            stable_ok;
        for (int i = 0; i < 5; i++) px[i] = 3*CW'($urandom);
        clear_scoreboard();
        acc       = 0;
        held      = '0;
        stable_ok = 1'b1;
        ready_i   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid_i = 1'b1;
            data_i  = px[acc];
            #1;
            if (c == 2) begin
                n_checks++;
                if (ready_o !== 1'b0) $display("FAIL bp_ready_drop: ready_o=%b want 0 in 3rd cycle", ready_o);
                else n_pass++;
            end
            if (ready_o) acc++;
            tick();
            if (c == 2) held = data_o;
            if (c > 2 && (data_o !== held || valid_o !== 1'b1)) stable_ok = 1'b0;
        end
        n_checks++;
        if (acc != 2) $display("FAIL bp_accepted: accepted %0d want 2", acc);
        else n_pass++;
        n_checks++;
        if (!stable_ok) $display("FAIL bp_stable: data_o=%0d want held %0d", data_o, held);
        else n_pass++;
        ready_i = 1'b1;
        guard   = 0;
        while (acc < 5 && guard < 50) begin
            data_i = px[acc];
            #1;
            if (ready_o) acc++;
            tick();
            guard++;
        end
        valid_i = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        n_checks++;
        if (obs_q.size() != 5) $display("FAIL bp_count: got %0d outputs want 5", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != ref_luma(px[i]))
                $display("FAIL bp_order%0d: got %0d want %0d", i, obs_q[i], ref_luma(px[i]));
            else n_pass++;
            $display("test_backpressure: out%0d=%0d expected=%0d", i, obs_q[i], ref_luma(px[i]));
        end
        clear_scoreboard();
    endtask

    task automatic test_back_to_back();
        logic [3*CW-1:0] px [16];
        logic            vo [22];
        int              acc;
        int              first;
        int              ones;
        int              run;
        for (int i = 0; i < 16; i++) px[i] = 3*CW'($urandom);
        clear_scoreboard();
        acc     = 0;
        ready_i = 1'b1;
        for (int c = 0; c < 22; c++) begin
            valid_i = (c < 16);
            data_i  = (c < 16) ? px[c] : '0;
            #1;
            vo[c] = valid_o;
            if (valid_i && ready_o) acc++;
            tick();
        end
        valid_i = 1'b0;
        first = -1;
        ones  = 0;
        run   = 0;
        for (int c = 0; c < 22; c++) begin
            if (vo[c] === 1'b1) begin
                if (first < 0) first = c;
                ones++;
                if (c - first == run) run++;
            end
        end
        n_checks++;
        if (acc != 16) $display("FAIL b2b_accept: accepted %0d want 16", acc);
        else n_pass++;
        n_checks++;
        if (first != 2) $display("FAIL b2b_latency: first valid at cycle %0d want 2", first);
        else n_pass++;
        n_checks++;
        if (ones != 16 || run != 16) $display("FAIL b2b_run: ones=%0d run=%0d want 16/16", ones, run);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != 16) $display("FAIL b2b_count: got %0d want 16", obs_q.size());
        else begin
            int bad;
            bad = 0;
            for (int i = 0; i < 16; i++) if (obs_q[i] != ref_luma(px[i])) bad++;
            if (bad != 0) $display("FAIL b2b_data: %0d mismatching samples want 0", bad);
            else n_pass++;
        end
        $display("test_back_to_back: accepted=%0d first=%0d run=%0d outputs=%0d", acc, first, run, obs_q.size());
        clear_scoreboard();
    endtask

    task automatic test_random();
        int   sent;
        int   cyc;
        int   bad;
        logic pending;
        clear_scoreboard();
        sent    = 0;
        cyc     = 0;
        pending = 1'b0;
        valid_i = 1'b0;
        while ((sent < 10000 || obs_q.size() < 10000) && cyc < 80000) begin
            if (!pending) begin
                valid_i = (sent < 10000) && ($urandom_range(0, 3) != 0);
                data_i  = 3*CW'($urandom);
            end
            ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (valid_i && ready_o) sent++;
            pending = valid_i && !ready_o;
            tick();
            cyc++;
        end
        valid_i = 1'b0;
        n_checks++;
        if (cyc >= 80000) $display("FAIL rand_timeout: %0d sent %0d received after %0d cycles", sent, obs_q.size(), cyc);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i] != exp_q[i]) begin
                if (bad == 0) $display("FAIL rand_data: sample %0d got %0d want %0d", i, obs_q[i], exp_q[i]);
                bad++;
            end
        end
        n_checks++;
        if (bad == 0) n_pass++;
        n_checks++;
        if (stab_err != 0) $display("FAIL rand_stable: %0d stall violations want 0", stab_err);
        else n_pass++;
        $display("test_random: sent=%0d received=%0d cycles=%0d stall_errors=%0d", sent, obs_q.size(), cyc, stab_err);
        clear_scoreboard();
    endtask

    task automatic test_mid_reset();
        clear_scoreboard();
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = rgb(255, 0, 0);
        tick();
        data_i  = rgb(0, 255, 0);
        tick();
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1)
            $display("FAIL mr_full: ready_o=%b valid_o=%b want 0/1", ready_o, valid_o);
        else n_pass++;
        reset_i = 1'b1;
        ready_i = 1'b1;
        data_i  = rgb(0, 0, 255);
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0)
            $display("FAIL mr_during: valid_o=%b ready_o=%b want 0/0", valid_o, ready_o);
        else n_pass++;
        tick();
        reset_i = 1'b0;
        valid_i = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || ready_o !== 1'b1)
            $display("FAIL mr_after: valid_o=%b data_o=%0d ready_o=%b want 0/0/1", valid_o, data_o, ready_o);
        else n_pass++;
        clear_scoreboard();
        for (int c = 0; c < 4; c++) tick();
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL mr_flushed: %0d flushed pixels emerged want 0", obs_q.size());
        else n_pass++;
        valid_i = 1'b1;
        data_i  = rgb(100, 100, 100);
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] != 100)
            $display("FAIL mr_resume: got %0d outputs (first %0d) want 1 output of 100",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1);
        else n_pass++;
        $display("test_mid_reset: post-reset outputs=%0d", obs_q.size());
        clear_scoreboard();
    endtask

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rgb2luma.md
RGB2LUMA -- requirements
Module: rgb2luma

Interface
REQ-001 Parameter: ChannelWidth, default 8, bits per colour channel and width of the luma output.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  reset, synchronous, active-high.
REQ-004 data_i  input  3*ChannelWidth  packed pixel {R,G,B}, with R in the MSBs.
REQ-005 valid_i  input  1  upstream asserts that data_i holds a pixel.
REQ-006 ready_o  output  1  block accepts data_i this cycle.
REQ-007 valid_o  output  1  data_o holds a luma sample.
REQ-008 data_o  output  ChannelWidth  unsigned luma Y.
REQ-009 ready_i  input  1  downstream accepts data_o this cycle.

Function
REQ-010 Transfer on either port occurs only in a cycle where valid and ready are both high; no other cycle transfers data.
REQ-011 Y = (77*R + 150*G + 29*B + 128) >> 8, computed unsigned.
REQ-012 Intermediate sum is at least ChannelWidth+9 bits wide so it never overflows.
REQ-013 Coefficients sum to 256, so Y <= 2^ChannelWidth - 1 and no saturation logic exists.
REQ-014 The datapath is two register stages:
- S1 registers the three products and a valid bit v1.
- S2 registers the rounded, shifted sum and a valid bit v2.
REQ-015 data_o is driven by the S2 data register and valid_o by v2; neither has a combinational path from data_i or valid_i.
REQ-016 Latency is exactly 2 cycles: a pixel accepted in cycle N appears with valid_o=1 in cycle N+2 when ready_i was high in cycle N+1.
REQ-017 S2 enable = !v2 | ready_i.
REQ-018 S1 enable = !v1 | S2 enable.
REQ-019 ready_o = S1 enable.
REQ-020 ready_o does not depend on valid_i.
REQ-021 When a stage is enabled, it loads the upstream data and valid bit; otherwise it holds both unchanged.
REQ-022 Bubbles collapse: with ready_i low, an empty S2 or S1 still accepts until both v1 and v2 are 1, then ready_o drops.
REQ-023 While valid_o=1 and ready_i=0, data_o and valid_o remain stable cycle to cycle.
REQ-024 With ready_i held high and valid_i held high, throughput is one pixel per cycle with no bubbles.
REQ-025 Simultaneous output transfer and input acceptance in the same cycle with both stages full is legal; all stages advance in that cycle.
REQ-026 Pixel order is preserved; no pixel is dropped or duplicated.

Reset
REQ-027 While reset_i=1 at a clock edge, v1 and v2 are cleared to 0 and the data registers are cleared to 0.
REQ-028 After reset: valid_o=0, data_o=0, ready_o=1.
REQ-029 Reset asserted mid-stream discards all in-flight pixels.
REQ-030 No transfer is reported in any cycle where reset_i=1.

Verification
REQ-031 Single pixels, ready_i=1, ChannelWidth=8:
- {255,255,255} -> 255
- {255,0,0} -> 77
- {0,255,0} -> 149
- {0,0,255} -> 29
- {0,0,0} -> 0
- {100,100,100} -> 100
Each appears exactly 2 cycles after acceptance.
REQ-032 Backpressure: stream 5 pixels with ready_i=0 -> exactly 2 accepted, ready_o=0 from the 3rd cycle, data_o stable. Then raise ready_i -> all 5 luma values emerge in order with no loss.
REQ-033 Full throughput: 16 back-to-back pixels with ready_i=1 -> valid_o high for 16 consecutive cycles starting 2 cycles after the first acceptance.
REQ-034 Random valid_i/ready_i toggling over 10k pixels -> output sequence equals the reference-model sequence; the stability check of REQ-023 never fails.
REQ-035 Assert reset_i for 1 cycle with both stages full -> next cycle valid_o=0, data_o=0, ready_o=1; none of the flushed pixels is ever output.
